// File: rtl/jtkicker_romarb_if.sv
// jtkicker_romarb_if
//  SDRAM read-port bundle between the ROM arbiter and the SDRAM controller.
//  master: arbiter side   - drives sdram_req/sdram_addr, receives ack and data.
//  slave : controller side - receives the request, drives ack/data_dst/data_rdy/data_read.
//   sdram_req   request, held until sdram_ack
//   sdram_addr  22-bit SDRAM 16-bit word address
//   sdram_ack   request accepted (one-cycle pulse)
//   data_dst    data_read valid this cycle
//   data_rdy    final beat of the transfer
//   data_read   16-bit read data
interface jtkicker_romarb_if;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_dst;
    logic        data_rdy;
    logic [15:0] data_read;

    modport master (
        output sdram_req, sdram_addr,
        input  sdram_ack, data_dst, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr,
        output sdram_ack, data_dst, data_rdy, data_read
    );
endinterface

// File: rtl/jtkicker_romarb.sv
// jtkicker_romarb
//  SDRAM ROM arbiter: SLOTS read slots, each with a one-word cache, sharing a
//  single SDRAM read port. Fixed-priority or round-robin grant, per-slot cache
//  invalidation, and traffic blocking while a ROM download is running.
// Ports
//  clk, rst     clock, asynchronous active-high reset
//  downloading  blocks new grants and clears every cache entry while high
//  slot_cs      per-slot read request level
//  slot_addr    packed slot addresses, slot k in [AW*k +: AW]
//  slot_inval   per-slot one-cycle cache clear pulse
//  slot_ok      per-slot data valid for the current address (registered)
//  slot_dout    packed per-slot data, slot k in [DW*k +: DW] (registered)
//  busy         transfer FSM not idle
//  sdram        SDRAM read port (master side)
module jtkicker_romarb #(
    parameter int                  SLOTS  = 4,
    parameter int                  AW     = 16,
    parameter int                  DW     = 32,
    parameter logic [SLOTS*22-1:0] OFFSET = '0,
    parameter int                  RROBIN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    input  logic [SLOTS-1:0]      slot_inval,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*DW-1:0]   slot_dout,
    output logic                  busy,
    jtkicker_romarb_if.master     sdram
);
    // Cache line width: one SDRAM word for 8/16-bit slots, two for 32-bit slots
    localparam int CW = (DW == 32) ? 32 : 16;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t            state_q, state_d;
    logic [SLOTS-1:0]  valid_q, valid_d;
    logic [AW-1:0]     tag_q   [SLOTS];
    logic [AW-1:0]     tag_d   [SLOTS];
    logic [CW-1:0]     cache_q [SLOTS];
    logic [CW-1:0]     cache_d [SLOTS];
    logic [SLOTS-1:0]  ok_q, ok_d;
    logic [SLOTS*DW-1:0] dout_q, dout_d;
    logic [SW-1:0]     g_q, g_d, rr_q, rr_d;
    logic [AW-1:0]     lat_word_q, lat_word_d;
    logic              req_q, req_d;
    logic [21:0]       addr_q, addr_d;
    logic              beat_q, beat_d;
    logic [CW-1:0]     buf_q, buf_d;

    logic [AW-1:0]     word    [SLOTS];
    logic [21:0]       sd_word [SLOTS];
    logic [SLOTS-1:0]  hit, pend, cand;
    logic              found;
    logic [SW-1:0]     pick;
    logic [SW:0]       sum;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [AW-1:0] a;
            assign a = slot_addr[AW*gi +: AW];

            // Word address as seen by the cache tag; byte/half selection is separate
            if (DW == 8) begin : g_w8
                assign word[gi] = {1'b0, a[AW-1:1]};
                assign dout_d[DW*gi +: DW] = a[0] ? cache_d[gi][15:8] : cache_d[gi][7:0];
            end else if (DW == 16) begin : g_w16
                assign word[gi] = a;
                assign dout_d[DW*gi +: DW] = cache_d[gi];
            end else begin : g_w32
                assign word[gi] = {a[AW-1:1], 1'b0};
                assign dout_d[DW*gi +: DW] = cache_d[gi];
            end

            // 22-bit modulo sum: offsets near the top of memory wrap to zero
            assign sd_word[gi] = OFFSET[22*gi +: 22] + 22'(word[gi]);
            assign hit[gi]     = valid_q[gi] & (tag_q[gi] == word[gi]);
            assign pend[gi]    = (state_q != IDLE) && (g_q == SW'(gi));
            assign cand[gi]    = slot_cs[gi] & ~hit[gi] & ~pend[gi] & ~downloading;
            // ok looks at the post-update cache so a fill is visible one cycle after data_rdy
            assign ok_d[gi]    = slot_cs[gi] & valid_d[gi] & (tag_d[gi] == word[gi]);
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        cache_d    = cache_q;
        g_d        = g_q;
        rr_d       = rr_q;
        lat_word_d = lat_word_q;
        req_d      = req_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        found      = 1'b0;
        pick       = '0;
        sum        = '0;

        // Scan candidates starting at rr_q (round-robin) or at slot 0 (fixed priority)
        for (int i = 0; i < SLOTS; i++) begin
            sum = ((RROBIN != 0) ? {1'b0, rr_q} : '0) + (SW+1)'(i);
            if (sum >= (SW+1)'(SLOTS)) sum = sum - (SW+1)'(SLOTS);
            if (!found && cand[sum[SW-1:0]]) begin
                found = 1'b1;
                pick  = sum[SW-1:0];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    g_d        = pick;
                    lat_word_d = word[pick];
                    addr_d     = sd_word[pick];
                    req_d      = 1'b1;
                    beat_d     = 1'b0;
                    rr_d       = (pick == SW'(SLOTS-1)) ? '0 : pick + 1'b1;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram.sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (sdram.data_dst) begin
                    if (DW == 32) begin
                        if (!beat_q) buf_d[15:0]      = sdram.data_read;
                        else         buf_d[CW-1 -: 16] = sdram.data_read;
                        beat_d = ~beat_q;
                    end else begin
                        buf_d[15:0] = sdram.data_read;
                    end
                end
                // The fill always lands on the latched slot/tag, even if the
                // requester has since moved on; the hit check sorts it out.
                if (sdram.data_rdy) begin
                    cache_d[g_q] = buf_d;
                    tag_d[g_q]   = lat_word_q;
                    valid_d[g_q] = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Invalidation is applied after the fill so a coincident pulse wins
        valid_d = valid_d & ~slot_inval;
        if (downloading) valid_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            ok_q       <= '0;
            dout_q     <= '0;
            g_q        <= '0;
            rr_q       <= '0;
            lat_word_q <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            beat_q     <= 1'b0;
            buf_q      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]   <= '0;
                cache_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            ok_q       <= ok_d;
            dout_q     <= dout_d;
            g_q        <= g_d;
            rr_q       <= rr_d;
            lat_word_q <= lat_word_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            buf_q      <= buf_d;
            tag_q      <= tag_d;
            cache_q    <= cache_d;
        end
    end

    assign sdram.sdram_req  = req_q;
    assign sdram.sdram_addr = addr_q;
    assign slot_ok          = ok_q;
    assign slot_dout        = dout_q;
    assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_jtkicker_romarb.sv
// tb_jtkicker_romarb
//  Directed bench for jtkicker_romarb. Four instances share the SDRAM-side
//  stimulus: u0 (DW=32 fixed priority), u1 (DW=32 round-robin), u2 (DW=8) and
//  u3 (DW=16, slot 0 offset at the top of memory). Instances not under test
//  are kept idle with their chip selects low.
module tb_jtkicker_romarb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        dl, ack, dst, rdy;
    logic [15:0] rd;
    logic [1:0]  inval;
    logic [1:0]  cs_a, cs_b, cs_c;
    logic [31:0] addr_a, addr_b, addr_c;
    logic [1:0]  ok0, ok1, ok2, ok3;
    logic [63:0] dout0, dout1;
    logic [15:0] dout2;
    logic [31:0] dout3;
    logic        busy0, busy1, busy2, busy3;

    jtkicker_romarb_if if0 ();
    jtkicker_romarb_if if1 ();
    jtkicker_romarb_if if2 ();
    jtkicker_romarb_if if3 ();

    assign if0.sdram_ack = ack; assign if0.data_dst = dst; assign if0.data_rdy = rdy; assign if0.data_read = rd;
    assign if1.sdram_ack = ack; assign if1.data_dst = dst; assign if1.data_rdy = rdy; assign if1.data_read = rd;
    assign if2.sdram_ack = ack; assign if2.data_dst = dst; assign if2.data_rdy = rdy; assign if2.data_read = rd;
    assign if3.sdram_ack = ack; assign if3.data_dst = dst; assign if3.data_rdy = rdy; assign if3.data_read = rd;

    jtkicker_romarb #(.SLOTS(2), .AW(16), .DW(32), .OFFSET({22'h000200, 22'h000100}), .RROBIN(0)) u0 (
        .clk(clk), .rst(rst), .downloading(dl), .slot_cs(cs_a), .slot_addr(addr_a),
        .slot_inval(inval), .slot_ok(ok0), .slot_dout(dout0), .busy(busy0), .sdram(if0));
    jtkicker_romarb #(.SLOTS(2), .AW(16), .DW(32), .OFFSET({22'h000200, 22'h000100}), .RROBIN(1)) u1 (
        .clk(clk), .rst(rst), .downloading(dl), .slot_cs(cs_a), .slot_addr(addr_a),
        .slot_inval(inval), .slot_ok(ok1), .slot_dout(dout1), .busy(busy1), .sdram(if1));
    jtkicker_romarb #(.SLOTS(2), .AW(16), .DW(8), .OFFSET({22'h000000, 22'h000000}), .RROBIN(0)) u2 (
        .clk(clk), .rst(rst), .downloading(dl), .slot_cs(cs_b), .slot_addr(addr_b),
        .slot_inval(inval), .slot_ok(ok2), .slot_dout(dout2), .busy(busy2), .sdram(if2));
    jtkicker_romarb #(.SLOTS(2), .AW(16), .DW(16), .OFFSET({22'h000000, 22'h3FFFFF}), .RROBIN(0)) u3 (
        .clk(clk), .rst(rst), .downloading(dl), .slot_cs(cs_c), .slot_addr(addr_c),
        .slot_inval(inval), .slot_ok(ok3), .slot_dout(dout3), .busy(busy3), .sdram(if3));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dl = 0; ack = 0; dst = 0; rdy = 0; rd = '0; inval = '0;
        cs_a = '0; cs_b = '0; cs_c = '0; addr_a = '0; addr_b = '0; addr_c = '0;

        // Reset state
        tick(); tick();
        check("rst_req",  64'(if0.sdram_req), 64'd0);
        check("rst_addr", 64'(if0.sdram_addr), 64'd0);
        check("rst_ok",   64'(ok0), 64'd0);
        check("rst_dout", dout0, 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        rst = 0;

        // DW=32 miss on slot 0, address 4
        cs_a = 2'b01; addr_a = {16'h0000, 16'h0004};
        tick();
        check("miss_req",   64'(if0.sdram_req), 64'd1);
        check("miss_addr",  64'(if0.sdram_addr), 64'h104);
        check("miss_busy",  64'(busy0), 64'd1);
        ack = 1; tick(); ack = 0;
        check("ack_req_low", 64'(if0.sdram_req), 64'd0);
        dst = 1; rd = 16'h1111; tick();
        rd = 16'h2222; rdy = 1; tick(); dst = 0; rdy = 0;
        check("fill_ok",   64'(ok0), 64'd1);
        check("fill_dout", 64'(dout0[31:0]), 64'h22221111);
        check("fill_busy", 64'(busy0), 64'd0);

        // Same address again: hit, no SDRAM traffic
        cs_a = 2'b00; tick();
        check("cs_drop_ok", 64'(ok0), 64'd0);
        cs_a = 2'b01; tick();
        check("rehit_ok",  64'(ok0), 64'd1);
        check("rehit_req", 64'(if0.sdram_req), 64'd0);

        // Both slots miss together: fixed priority picks 0, round-robin picks 1
        cs_a = 2'b11; addr_a = {16'h0020, 16'h0010};
        tick();
        check("arb_fixed_addr", 64'(if0.sdram_addr), 64'h110);
        check("arb_rr_addr",    64'(if1.sdram_addr), 64'h220);
        ack = 1; tick(); ack = 0;
        dst = 1; rd = 16'hAAAA; tick();
        rd = 16'hBBBB; rdy = 1; tick(); dst = 0; rdy = 0;
        check("arb1_fixed_ok", 64'(ok0), 64'b01);
        check("arb1_rr_ok",    64'(ok1), 64'b10);
        check("arb1_rr_dout",  64'(dout1[63:32]), 64'hBBBBAAAA);
        tick();
        check("arb2_fixed_addr", 64'(if0.sdram_addr), 64'h220);
        check("arb2_rr_addr",    64'(if1.sdram_addr), 64'h110);
        check("arb2_req",        64'(if0.sdram_req), 64'd1);
        ack = 1; tick(); ack = 0;
        dst = 1; rd = 16'h3333; tick();
        rd = 16'h4444; rdy = 1; tick(); dst = 0; rdy = 0;
        check("arb2_fixed_ok",   64'(ok0), 64'b11);
        check("arb2_fixed_dout", dout0, 64'h44443333_BBBBAAAA);
        check("arb2_rr_dout",    dout1, 64'hBBBBAAAA_44443333);

        // Invalidate slot 0: ok drops, then the slot is refetched
        inval = 2'b01; tick(); inval = 2'b00;
        check("inval_ok", 64'(ok0), 64'b10);
        tick();
        check("inval_refetch_req",  64'(if0.sdram_req), 64'd1);
        check("inval_refetch_addr", 64'(if0.sdram_addr), 64'h110);

        // Download starts during WAIT_DATA: transfer ends, nothing becomes valid
        ack = 1; tick(); ack = 0;
        dl = 1;
        dst = 1; rd = 16'h5555; tick();
        rd = 16'h6666; rdy = 1; tick(); dst = 0; rdy = 0;
        check("dl_fill_ok",   64'(ok0), 64'd0);
        check("dl_fill_busy", 64'(busy0), 64'd0);
        tick();
        check("dl_hold_req", 64'(if0.sdram_req), 64'd0);
        check("dl_hold_ok",  64'(ok1), 64'd0);
        dl = 0; tick();
        check("dl_end_fixed_addr", 64'(if0.sdram_addr), 64'h110);
        check("dl_end_rr_addr",    64'(if1.sdram_addr), 64'h220);

        // Asynchronous reset while waiting for ack
        check("pre_rst_req", 64'(if0.sdram_req), 64'd1);
        #3 rst = 1; #1;
        check("async_rst_req",  64'(if0.sdram_req), 64'd0);
        check("async_rst_addr", 64'(if0.sdram_addr), 64'd0);
        check("async_rst_busy", 64'(busy1), 64'd0);
        cs_a = 2'b00;
        tick(); rst = 0;

        // DW=8: fill word 8 via address 0x10, then byte 0x11 hits with no request
        cs_b = 2'b01; addr_b = {16'h0000, 16'h0010};
        tick();
        check("b8_req",  64'(if2.sdram_req), 64'd1);
        check("b8_addr", 64'(if2.sdram_addr), 64'h8);
        ack = 1; tick(); ack = 0;
        dst = 1; rd = 16'hABCD; rdy = 1; tick(); dst = 0; rdy = 0;
        check("b8_ok",     64'(ok2), 64'b01);
        check("b8_dout_lo", 64'(dout2[7:0]), 64'hCD);
        addr_b = {16'h0000, 16'h0011}; tick();
        check("b8_dout_hi", 64'(dout2[7:0]), 64'hAB);
        check("b8_hi_ok",   64'(ok2), 64'b01);
        check("b8_hi_req",  64'(if2.sdram_req), 64'd0);
        check("b8_hi_busy", 64'(busy2), 64'd0);
        cs_b = 2'b00;

        // DW=16 with offset 0x3FFFFF: address wraps to 1
        cs_c = 2'b01; addr_c = {16'h0000, 16'h0002};
        tick();
        check("wrap_req",  64'(if3.sdram_req), 64'd1);
        check("wrap_addr", 64'(if3.sdram_addr), 64'h000001);
        ack = 1; tick(); ack = 0;
        dst = 1; rd = 16'h5A5A; rdy = 1; tick(); dst = 0; rdy = 0;
        check("w16_ok",   64'(ok3), 64'b01);
        check("w16_dout", 64'(dout3[15:0]), 64'h5A5A);
        cs_c = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
